// File: rtl/traffic_pkg.sv
// Shared definitions for the Night Mode blink path: monitor state encoding,
// fault codes and the nominal blink timing shared with blink_generator.
package traffic_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SYNC    = 3'd1,
        ST_MEASURE = 3'd2,
        ST_LOCKED  = 3'd3,
        ST_FAULT   = 3'd4
    } mon_state_t;

    localparam logic [1:0] FC_NONE        = 2'b00;
    localparam logic [1:0] FC_SHORT       = 2'b01;
    localparam logic [1:0] FC_LONG        = 2'b10;
    localparam logic [1:0] FC_IDLE_ACTIVE = 2'b11;

    localparam int DEF_HALF_PERIOD_TICKS = 25_000_000;
    localparam int DEF_TOL_TICKS         = 1_250_000;
    localparam int DEF_LOCK_HALVES       = 4;
    localparam int DEF_CNT_W             = 26;

endpackage

// File: rtl/edge_interval_counter.sv
// Edge detector on blink_in plus a saturating counter of cycles since the
// last edge; interval is the live count, meaningful in the cycle blink_edge is high.
module edge_interval_counter #(
    parameter int CNT_W = 26
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             blink_in,
    output logic             blink_edge,
    output logic             blink_rise,
    output logic [CNT_W-1:0] interval
);

    logic             blink_q;
    logic [CNT_W-1:0] cnt;

    assign blink_edge = blink_in != blink_q;
    assign blink_rise = blink_in & ~blink_q;
    assign interval   = cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            blink_q <= 1'b0;
            cnt     <= '0;
        end else begin
            blink_q <= blink_in;
            if (clear) begin
                cnt <= '0;
            end else if (blink_edge) begin
                cnt <= CNT_W'(1);
            end else if (cnt != '1) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/blink_monitor.sv
// Lamp-health checker: verifies the flashing-yellow drive toggles at the nominal
// half-period and latches a coded fault when it is too fast, stuck or active while disabled.
module blink_monitor
    import traffic_pkg::*;
#(
    parameter int HALF_PERIOD_TICKS = DEF_HALF_PERIOD_TICKS,
    parameter int TOL_TICKS         = DEF_TOL_TICKS,
    parameter int LOCK_HALVES       = DEF_LOCK_HALVES,
    parameter int CNT_W             = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             blink_in,
    input  logic             clr_fault,
    output logic             locked,
    output logic             fault,
    output logic [1:0]       fault_code,
    output logic [CNT_W-1:0] half_period,
    output mon_state_t       state_dbg
);

    localparam int LO_INT = (HALF_PERIOD_TICKS > TOL_TICKS) ? HALF_PERIOD_TICKS - TOL_TICKS : 0;
    localparam logic [CNT_W:0] WIN_LO = (CNT_W + 1)'(LO_INT);
    localparam logic [CNT_W:0] WIN_HI = (CNT_W + 1)'(HALF_PERIOD_TICKS + TOL_TICKS);
    localparam int GOOD_W = $clog2(LOCK_HALVES + 1);
    localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_HALVES - 1);

    // The counter must be able to reach the timeout value before it saturates.
    if (64'(HALF_PERIOD_TICKS) + 64'(TOL_TICKS) + 64'd1 > (64'd1 << CNT_W) - 64'd1) begin : g_cnt_w_check
        $error("CNT_W too narrow for HALF_PERIOD_TICKS+TOL_TICKS+1");
    end

    mon_state_t        state, state_n;
    logic [1:0]        code_n;
    logic [GOOD_W-1:0] good_cnt, good_n;
    logic [CNT_W-1:0]  hp_n;
    logic [1:0]        hi_cnt;
    logic              cnt_clear, blink_edge, blink_rise;
    logic [CNT_W-1:0]  interval;
    logic [CNT_W:0]    interval_x;
    logic              too_short, timeout, idle_active;

    assign cnt_clear   = (state == ST_IDLE && !enable) || state == ST_FAULT;
    assign interval_x  = {1'b0, interval};
    assign too_short   = interval_x < WIN_LO;
    assign timeout     = interval_x > WIN_HI;
    assign idle_active = blink_in && hi_cnt == 2'd2;
    assign state_dbg   = state;

    edge_interval_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk        (clk),
        .reset      (reset),
        .clear      (cnt_clear),
        .blink_in   (blink_in),
        .blink_edge (blink_edge),
        .blink_rise (blink_rise),
        .interval   (interval)
    );

    always_comb begin
        state_n = state;
        code_n  = fault_code;
        good_n  = '0;
        hp_n    = half_period;
        case (state)
            ST_IDLE: begin
                if (enable) begin
                    state_n = ST_SYNC;
                end else if (idle_active) begin
                    state_n = ST_FAULT;
                    code_n  = FC_IDLE_ACTIVE;
                end
            end
            ST_SYNC: begin
                if (timeout) begin
                    state_n = ST_FAULT;
                    code_n  = FC_LONG;
                end else if (!enable) begin
                    state_n = ST_IDLE;
                end else if (blink_rise) begin
                    state_n = ST_MEASURE;
                end
            end
            ST_MEASURE, ST_LOCKED: begin
                if (state == ST_MEASURE) good_n = good_cnt;
                if (blink_edge) hp_n = interval;
                // Fault detection outranks enable falling in the same cycle.
                if (blink_edge && too_short) begin
                    state_n = ST_FAULT;
                    code_n  = FC_SHORT;
                end else if (timeout) begin
                    state_n = ST_FAULT;
                    code_n  = FC_LONG;
                end else if (!enable) begin
                    state_n = ST_IDLE;
                    good_n  = '0;
                end else if (blink_edge && state == ST_MEASURE) begin
                    if (good_cnt == GOOD_LAST) state_n = ST_LOCKED;
                    else good_n = good_cnt + 1'b1;
                end
            end
            ST_FAULT: begin
                if (clr_fault) begin
                    state_n = ST_IDLE;
                    code_n  = FC_NONE;
                end
            end
            default: begin
                state_n = ST_IDLE;
                code_n  = FC_NONE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            good_cnt    <= '0;
            hi_cnt      <= '0;
            locked      <= 1'b0;
            fault       <= 1'b0;
            fault_code  <= FC_NONE;
            half_period <= '0;
        end else begin
            state       <= state_n;
            good_cnt    <= good_n;
            locked      <= state_n == ST_LOCKED;
            fault       <= state_n == ST_FAULT;
            fault_code  <= code_n;
            half_period <= hp_n;
            // Consecutive high samples while disabled; the first two are release-lag grace.
            if (state == ST_IDLE && !enable && blink_in)
                hi_cnt <= (hi_cnt == 2'd2) ? 2'd2 : hi_cnt + 2'd1;
            else
                hi_cnt <= '0;
        end
    end

endmodule
